blake_work_sched: RTL and testbench
===================================

# blake_work_sched

Work scheduler between the ZTEX host byte bus and the Blake hashing pipeline in the Ztex-1-15x miner top. Assembles 44-byte work units written by the host, loads them into the core, owns the nonce counter that feeds the pipeline, and buffers golden nonces for host readback. It is the only block that starts, restarts or stops the hasher.

## Interface

Parameters:
- DATA_BYTES, 44, work unit length in bytes (midstate 32 + tail 12)
- NONCE_STRIDE, 1, nonce increment per clock while running
- GN_DEPTH, 2, golden-nonce buffer entries (power of 2)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- select  in  1  host chip select; bus ignored while low
- wr_en  in  1  host write strobe, byte on din
- rd_en  in  1  host read strobe, advances dout byte
- din  in  8  host write byte
- dout  out  8  host read byte
- work_data  out  8*DATA_BYTES  work unit to core, byte 0 in bits [7:0]
- core_load  out  1  one-cycle pulse: core latches work_data
- nonce  out  32  nonce presented to pipeline input
- running  out  1  high while nonce is advancing
- golden_valid  in  1  core reports a hit this cycle
- golden_nonce  in  32  hit nonce (already pipeline-adjusted)
- gn_avail  out  1  buffer non-empty
- gn_overflow  out  1  sticky: a hit was dropped

## Operation

- States: IDLE, RUN, EXHAUSTED. Reset -> IDLE.
- Load path (independent of state): on clk with select & wr_en, din shifts into shadow register at byte index wr_idx, wr_idx++. When the byte at index DATA_BYTES-1 is accepted: shadow copied to work_data, core_load pulses, nonce <= 0, state -> RUN, wr_idx <= 0.
- select low for any cycle with 0 < wr_idx: partial load discarded, wr_idx <= 0, work_data unchanged, state unchanged.
- RUN: nonce <= nonce + NONCE_STRIDE each cycle. If the add carries out of 32 bits, nonce holds at its last value and state -> EXHAUSTED, running low.
- EXHAUSTED/IDLE: nonce holds; only a completed load leaves them.
- A load completing in RUN restarts: nonce <= 0, core_load pulses, state stays RUN.
- Golden buffer: FIFO of GN_DEPTH x 32. golden_valid while not full -> push. While full -> drop, gn_overflow <= 1. gn_overflow clears only on reset or a completed load.
- Readback: dout = byte rd_idx of FIFO head (rd_idx 0 = bits [7:0]); 8'hFF when empty. select & rd_en with non-empty FIFO: rd_idx++; on rd_idx==3 pop head, rd_idx <= 0. rd_en on empty FIFO ignored. select low resets rd_idx to 0 (no pop).
- Simultaneous push and pop on full FIFO: pop first, push accepted, no overflow.
- wr_en and rd_en both high: both honoured independently.
- golden_valid in IDLE/EXHAUSTED still pushed (pipeline drain).

## Timing

- Reset values: dout 8'hFF, work_data 0, core_load 0, nonce 0, running 0, gn_avail 0, gn_overflow 0; wr_idx, rd_idx, FIFO pointers 0.
- Last load byte sampled at edge N: work_data, core_load=1, nonce=0, running=1 visible after edge N; core_load low after N+1; nonce=NONCE_STRIDE after N+1.
- golden_valid sampled at edge M: gn_avail high after M.
- dout is combinational from head/rd_idx; new byte valid after the edge that consumed rd_en.
- reset_n low mid-load or mid-read: all state cleared immediately, independent of clk.

## Test plan

- Reset then write bytes 0x00..0x2B with select high -> one core_load pulse the cycle after byte 0x2B; work_data[7:0]=0x00, [351:344]=0x2B; nonce 0,1,2... ; running=1.
- Write 20 bytes, drop select 1 cycle, write 44 bytes -> exactly one core_load; work_data reflects only the second 44 bytes.
- Force nonce start near wrap (NONCE_STRIDE=1, preload via 0xFFFFFFF0 in bench override) -> nonce stops at 0xFFFFFFFF, running=0, state EXHAUSTED; new load restarts at 0.
- golden_valid with 0xDEADBEEF -> gn_avail=1; four reads give dout 0xEF,0xBE,0xAD,0xDE; then gn_avail=0, dout=0xFF.
- Three golden_valid pulses with no reads (GN_DEPTH=2) -> gn_overflow=1, readback yields first two nonces only; completing a load clears gn_overflow.
- Assert reset_n low mid-run between clock edges -> all outputs at reset values before next edge.

Source files
------------

// File: rtl/blake_work_sched.sv
// blake_work_sched
// Work scheduler between the host byte bus and the Blake hashing pipeline.
// It assembles DATA_BYTES-byte work units from host writes, hands each
// completed unit to the core with a one-cycle core_load pulse, owns the nonce
// counter that feeds the pipeline, and buffers golden nonces so the host can
// read them back a byte at a time.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   select       host chip select; the bus is ignored while low
//   wr_en/din    host write strobe and byte
//   rd_en/dout   host read strobe and byte (dout is 8'hFF when buffer empty)
//   work_data    current work unit, byte 0 in bits [7:0]
//   core_load    one-cycle pulse telling the core to latch work_data
//   nonce        nonce presented to the pipeline input
//   running      high while the nonce is advancing
//   golden_valid/golden_nonce  hit reported by the core
//   gn_avail     golden buffer non-empty
//   gn_overflow  sticky flag: a hit was dropped because the buffer was full
//
// NONCE_START is the nonce value a completed load starts from (0 in normal
// use; a bench can raise it to reach the exhaustion point quickly).
module blake_work_sched #(
  parameter int          DATA_BYTES   = 44,
  parameter logic [31:0] NONCE_STRIDE = 32'd1,
  parameter int          GN_DEPTH     = 2,
  parameter logic [31:0] NONCE_START  = 32'd0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    select,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [7:0]              din,
  output logic [7:0]              dout,
  output logic [8*DATA_BYTES-1:0] work_data,
  output logic                    core_load,
  output logic [31:0]             nonce,
  output logic                    running,
  input  logic                    golden_valid,
  input  logic [31:0]             golden_nonce,
  output logic                    gn_avail,
  output logic                    gn_overflow
);

  localparam int IW = $clog2(DATA_BYTES);
  localparam int PW = $clog2(GN_DEPTH);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_EXHAUSTED = 2'd2;

  logic [1:0]              state_r;
  logic [IW-1:0]           wr_idx_r;
  logic [8*DATA_BYTES-1:0] shadow_r;
  logic [8*DATA_BYTES-1:0] shadow_next_s;
  logic [8*DATA_BYTES-1:0] work_data_r;
  logic                    core_load_r;
  logic [31:0]             nonce_r;
  logic [32:0]             nonce_sum_s;
  logic                    accept_s;
  logic                    load_done_s;

  logic [31:0]             gn_mem_r [GN_DEPTH];
  logic [PW-1:0]           gn_wptr_r;
  logic [PW-1:0]           gn_rptr_r;
  logic [PW:0]             gn_cnt_r;
  logic [1:0]              rd_idx_r;
  logic                    gn_overflow_r;
  logic                    gn_full_s;
  logic                    gn_empty_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    drop_s;
  logic [31:0]             head_s;
  logic [7:0]              dout_s;

  assign accept_s    = select & wr_en;
  assign load_done_s = accept_s & (wr_idx_r == IW'(DATA_BYTES - 1));
  // 33-bit add so the carry out of the nonce is visible directly.
  assign nonce_sum_s = {1'b0, nonce_r} + {1'b0, NONCE_STRIDE};

  assign gn_full_s  = (gn_cnt_r == (PW+1)'(GN_DEPTH));
  assign gn_empty_s = (gn_cnt_r == '0);
  // The head leaves when its last byte is consumed; that frees a slot for a
  // hit arriving in the same cycle, so a full buffer does not drop it.
  assign pop_s  = select & rd_en & ~gn_empty_s & (rd_idx_r == 2'd3);
  assign push_s = golden_valid & (~gn_full_s | pop_s);
  assign drop_s = golden_valid & gn_full_s & ~pop_s;

  // Shadow image with the byte accepted this cycle merged in, so the final
  // byte reaches work_data on the same edge that accepts it.
  always_comb begin
    shadow_next_s = shadow_r;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (accept_s && (wr_idx_r == IW'(i))) begin
        shadow_next_s[8*i +: 8] = din;
      end else begin
        shadow_next_s[8*i +: 8] = shadow_r[8*i +: 8];
      end
    end
  end

  // Work-unit assembly: byte index, shadow register and load hand-off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_idx_r    <= '0;
      shadow_r    <= '0;
      work_data_r <= '0;
      core_load_r <= 1'b0;
    end else begin
      core_load_r <= load_done_s;
      if (!select) begin
        // Dropping select abandons any partial unit.
        wr_idx_r <= '0;
      end else if (load_done_s) begin
        wr_idx_r    <= '0;
        shadow_r    <= shadow_next_s;
        work_data_r <= shadow_next_s;
      end else if (accept_s) begin
        wr_idx_r <= wr_idx_r + IW'(1);
        shadow_r <= shadow_next_s;
      end else begin
        wr_idx_r <= wr_idx_r;
      end
    end
  end

  // Run state and nonce counter; a completed load always (re)starts a run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      nonce_r <= 32'd0;
    end else if (load_done_s) begin
      state_r <= ST_RUN;
      nonce_r <= NONCE_START;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (nonce_sum_s[32]) begin
            // Nonce space used up: keep the last nonce and stop.
            state_r <= ST_EXHAUSTED;
          end else begin
            nonce_r <= nonce_sum_s[31:0];
          end
        end
        ST_IDLE:      state_r <= ST_IDLE;
        ST_EXHAUSTED: state_r <= ST_EXHAUSTED;
        default:      state_r <= ST_IDLE;
      endcase
    end
  end

  // Golden-nonce FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < GN_DEPTH; i++) begin
        gn_mem_r[i] <= 32'd0;
      end
      gn_wptr_r <= '0;
      gn_rptr_r <= '0;
      gn_cnt_r  <= '0;
    end else begin
      if (push_s) begin
        gn_mem_r[gn_wptr_r] <= golden_nonce;
        gn_wptr_r           <= gn_wptr_r + PW'(1);
      end
      if (pop_s) begin
        gn_rptr_r <= gn_rptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   gn_cnt_r <= gn_cnt_r + (PW+1)'(1);
        2'b01:   gn_cnt_r <= gn_cnt_r - (PW+1)'(1);
        default: gn_cnt_r <= gn_cnt_r;
      endcase
    end
  end

  // Readback byte index and sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_idx_r      <= 2'd0;
      gn_overflow_r <= 1'b0;
    end else begin
      if (!select) begin
        rd_idx_r <= 2'd0;
      end else if (rd_en && !gn_empty_s) begin
        rd_idx_r <= rd_idx_r + 2'd1;  // wraps 3 -> 0 together with the pop
      end else begin
        rd_idx_r <= rd_idx_r;
      end
      // A drop in the same cycle as a load still counts as a lost hit.
      if (drop_s) begin
        gn_overflow_r <= 1'b1;
      end else if (load_done_s) begin
        gn_overflow_r <= 1'b0;
      end else begin
        gn_overflow_r <= gn_overflow_r;
      end
    end
  end

  // Host read byte: selected byte of the FIFO head, all-ones when empty.
  always_comb begin
    head_s = gn_mem_r[gn_rptr_r];
    dout_s = 8'hFF;
    if (!gn_empty_s) begin
      case (rd_idx_r)
        2'd0:    dout_s = head_s[7:0];
        2'd1:    dout_s = head_s[15:8];
        2'd2:    dout_s = head_s[23:16];
        2'd3:    dout_s = head_s[31:24];
        default: dout_s = 8'hFF;
      endcase
    end else begin
      dout_s = 8'hFF;
    end
  end

  assign dout        = dout_s;
  assign work_data   = work_data_r;
  assign core_load   = core_load_r;
  assign nonce       = nonce_r;
  assign running     = (state_r == ST_RUN);
  assign gn_avail    = ~gn_empty_s;
  assign gn_overflow = gn_overflow_r;

endmodule

// File: tb/tb_blake_work_sched.sv
// Directed self-checking bench for blake_work_sched. Instance u1 uses the
// default nonce start; instance u2 starts each run at 32'hFFFFFFF0 so the
// exhaustion behaviour is reachable in a few cycles.
module tb_blake_work_sched;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         sel1 = 1'b0;
  logic         sel2 = 1'b0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [7:0]   din = 8'h00;
  logic         gv = 1'b0;
  logic         gv2 = 1'b0;
  logic [31:0]  gnonce = 32'h0;

  logic [7:0]   dout1, dout2;
  logic [351:0] wd1, wd2;
  logic         cl1, cl2, run1, run2, av1, av2, ov1, ov2;
  logic [31:0]  nonce1, nonce2;

  int tests = 0;
  int fails = 0;
  int load_cnt1 = 0;
  int snap;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cl1) load_cnt1 <= load_cnt1 + 1;
  end

  blake_work_sched u1 (
    .clk(clk), .reset_n(reset_n), .select(sel1), .wr_en(wr_en), .rd_en(rd_en),
    .din(din), .dout(dout1), .work_data(wd1), .core_load(cl1), .nonce(nonce1),
    .running(run1), .golden_valid(gv), .golden_nonce(gnonce), .gn_avail(av1),
    .gn_overflow(ov1)
  );

  blake_work_sched #(.NONCE_START(32'hFFFF_FFF0)) u2 (
    .clk(clk), .reset_n(reset_n), .select(sel2), .wr_en(wr_en), .rd_en(rd_en),
    .din(din), .dout(dout2), .work_data(wd2), .core_load(cl2), .nonce(nonce2),
    .running(run2), .golden_valid(gv2), .golden_nonce(gnonce), .gn_avail(av2),
    .gn_overflow(ov2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write n bytes (value i ^ xr) to instance 'which', back to back.
  task automatic wr_bytes(input int which, input int n, input logic [7:0] xr);
    if (which == 1) sel1 = 1'b1; else sel2 = 1'b1;
    for (int i = 0; i < n; i++) begin
      din   = 8'(i) ^ xr;
      wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic push(input logic [31:0] v);
    gv = 1'b1;
    gnonce = v;
    tick();
    gv = 1'b0;
  endtask

  task automatic rd_n(input int n);
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_dout", 64'(dout1), 64'h00FF);
    chk("rst_work_data", 64'(wd1[63:0] | wd1[351:288]), 64'h0);
    chk("rst_core_load", 64'(cl1), 64'h0);
    chk("rst_nonce", 64'(nonce1), 64'h0);
    chk("rst_running", 64'(run1), 64'h0);
    chk("rst_gn_avail", 64'(av1), 64'h0);
    chk("rst_gn_overflow", 64'(ov1), 64'h0);
    reset_n = 1'b1;
    tick();

    // Full load of bytes 0x00..0x2B
    snap = load_cnt1;
    wr_bytes(1, 43, 8'h00);
    chk("no_early_load", 64'(cl1), 64'h0);
    din = 8'h2B; wr_en = 1'b1; tick(); wr_en = 1'b0;
    chk("load1_pulse", 64'(cl1), 64'h1);
    chk("load1_byte0", 64'(wd1[7:0]), 64'h00);
    chk("load1_byte43", 64'(wd1[351:344]), 64'h2B);
    chk("load1_byte19", 64'(wd1[159:152]), 64'h13);
    chk("load1_nonce0", 64'(nonce1), 64'h0);
    chk("load1_running", 64'(run1), 64'h1);
    tick();
    chk("load1_pulse_end", 64'(cl1), 64'h0);
    chk("load1_nonce1", 64'(nonce1), 64'h1);
    tick();
    chk("load1_nonce2", 64'(nonce1), 64'h2);
    chk("load1_count", 64'(load_cnt1 - snap), 64'h1);

    // Partial load abandoned by select drop, then a full load in RUN
    for (int i = 0; i < 5; i++) tick();
    snap = load_cnt1;
    wr_bytes(1, 20, 8'h5A);
    chk("partial_wd_unchanged", 64'(wd1[159:152]), 64'h13);
    sel1 = 1'b0; tick(); sel1 = 1'b1;
    wr_bytes(1, 44, 8'hA5);
    chk("load2_pulse", 64'(cl1), 64'h1);
    chk("load2_restart_nonce", 64'(nonce1), 64'h0);
    chk("load2_running", 64'(run1), 64'h1);
    chk("load2_byte0", 64'(wd1[7:0]), 64'hA5);
    chk("load2_byte10", 64'(wd1[87:80]), 64'hAF);
    chk("load2_byte43", 64'(wd1[351:344]), 64'h8E);
    tick();
    chk("load2_count", 64'(load_cnt1 - snap), 64'h1);

    // Nonce exhaustion on u2
    sel1 = 1'b0;
    chk("u2_idle_running", 64'(run2), 64'h0);
    wr_bytes(2, 44, 8'h00);
    chk("u2_start_nonce", 64'(nonce2), 64'hFFFF_FFF0);
    chk("u2_running", 64'(run2), 64'h1);
    for (int i = 0; i < 15; i++) tick();
    chk("u2_last_nonce", 64'(nonce2), 64'hFFFF_FFFF);
    chk("u2_still_running", 64'(run2), 64'h1);
    tick();
    chk("u2_exh_nonce", 64'(nonce2), 64'hFFFF_FFFF);
    chk("u2_exh_running", 64'(run2), 64'h0);
    tick(); tick();
    chk("u2_exh_hold", 64'(nonce2), 64'hFFFF_FFFF);
    chk("u2_exh_hold_run", 64'(run2), 64'h0);
    wr_bytes(2, 44, 8'h11);
    chk("u2_reload_nonce", 64'(nonce2), 64'hFFFF_FFF0);
    chk("u2_reload_running", 64'(run2), 64'h1);
    chk("u2_reload_pulse", 64'(cl2), 64'h1);
    sel2 = 1'b0;

    // Golden nonce readback
    sel1 = 1'b1;
    push(32'hDEAD_BEEF);
    chk("gn_avail", 64'(av1), 64'h1);
    chk("gn_byte0", 64'(dout1), 64'hEF);
    rd_en = 1'b1;
    tick(); chk("gn_byte1", 64'(dout1), 64'hBE);
    tick(); chk("gn_byte2", 64'(dout1), 64'hAD);
    tick(); chk("gn_byte3", 64'(dout1), 64'hDE);
    tick(); chk("gn_empty_dout", 64'(dout1), 64'hFF);
    chk("gn_empty_avail", 64'(av1), 64'h0);
    tick(); chk("gn_rd_on_empty", 64'(dout1), 64'hFF);
    rd_en = 1'b0;

    // Push and pop together on a full buffer
    push(32'hA3A2_A1A0);
    push(32'hB3B2_B1B0);
    rd_n(3);
    chk("full_head_byte3", 64'(dout1), 64'hA3);
    rd_en = 1'b1; gv = 1'b1; gnonce = 32'hC3C2_C1C0;
    tick();
    rd_en = 1'b0; gv = 1'b0;
    chk("pushpop_no_ovf", 64'(ov1), 64'h0);
    chk("pushpop_head_b", 64'(dout1), 64'hB0);
    rd_n(4);
    chk("pushpop_head_c", 64'(dout1), 64'hC0);
    rd_n(4);
    chk("pushpop_drained", 64'(av1), 64'h0);

    // select low returns rd_idx to byte 0 without popping
    push(32'hD3D2_D1D0);
    rd_n(1);
    chk("sel_rd_byte1", 64'(dout1), 64'hD1);
    sel1 = 1'b0; tick(); sel1 = 1'b1;
    chk("sel_rd_reset", 64'(dout1), 64'hD0);
    chk("sel_rd_nopop", 64'(av1), 64'h1);
    rd_n(4);

    // Overflow: three hits without reads
    push(32'h4433_2211);
    push(32'h8877_6655);
    push(32'hCCBB_AA99);
    chk("ovf_set", 64'(ov1), 64'h1);
    chk("ovf_head_first", 64'(dout1), 64'h11);
    rd_n(4);
    chk("ovf_head_second", 64'(dout1), 64'h55);
    rd_n(4);
    chk("ovf_third_dropped", 64'(dout1), 64'hFF);
    chk("ovf_sticky", 64'(ov1), 64'h1);
    wr_bytes(1, 44, 8'h33);
    chk("ovf_cleared_by_load", 64'(ov1), 64'h0);

    // Asynchronous reset between edges while running with a buffered hit
    push(32'h1234_5678);
    tick();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_dout", 64'(dout1), 64'hFF);
    chk("arst_gn_avail", 64'(av1), 64'h0);
    chk("arst_nonce", 64'(nonce1), 64'h0);
    chk("arst_running", 64'(run1), 64'h0);
    chk("arst_work_data", 64'(wd1[63:0] | wd1[351:288]), 64'h0);
    chk("arst_u2_nonce", 64'(nonce2), 64'h0);
    #10 reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
